// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared constants, requester index type and grant decode helper
package ram_arb_pkg;
   localparam int NREQ = 2;
   typedef logic [0:0] req_idx_t;
   function automatic req_idx_t onehot_to_idx(input logic [NREQ-1:0] oh);
      return req_idx_t'(oh[1] & ~oh[0]);
   endfunction
endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-way arbiter, round-robin or fixed priority (RAM_ARB_FIXED_PRIO_EN)
module rr_arbiter_2
   import ram_arb_pkg::*;
(
   input  logic            clock,
   input  logic            reset,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] grant,
   output req_idx_t        gnt_idx
);
`ifdef RAM_ARB_FIXED_PRIO_EN
   // requester 0 wins every tie, no pointer state
   always_comb grant = reset ? 2'b00 : req[0] ? 2'b01 : {req[1], 1'b0};
`else
   req_idx_t r_rr_ptr;
   // a single request wins outright; on a tie the pointed-to requester wins
   always_comb grant = reset ? 2'b00 : (&req) ? (r_rr_ptr[0] ? 2'b10 : 2'b01) : req;
   // after any grant, favour the other requester next time
   always_ff @(posedge clock or posedge reset)
      if (reset) r_rr_ptr <= '0;
      else if (|grant) r_rr_ptr <= ~gnt_idx;
`endif
   assign gnt_idx = onehot_to_idx(grant);
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares a sync-read single-port RAM between two requesters (option RAM_ARB_FIXED_PRIO_EN)
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int AWIDTH = 3,
   parameter int DWIDTH = 32
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ-1:0]        req_we,
   input  logic [NREQ*AWIDTH-1:0] req_addr,
   input  logic [NREQ*DWIDTH-1:0] req_wdata,
   output logic [NREQ-1:0]        req_ready,
   output logic [NREQ-1:0]        rsp_valid,
   output logic                   rsp_we,
   output logic [DWIDTH-1:0]      rsp_rdata,
   output logic [AWIDTH-1:0]      ram_addr,
   output logic [DWIDTH-1:0]      ram_din,
   output logic                   ram_we,
   input  logic [DWIDTH-1:0]      ram_dout
);
   logic [NREQ-1:0] w_grant;
   req_idx_t        w_idx;
   logic            w_any;
   logic [NREQ-1:0] r_rsp_valid_q;
   logic            r_rsp_we_q;
   rr_arbiter_2 u_arb (
      .clock   (clock),
      .reset   (reset),
      .req     (req_valid),
      .grant   (w_grant),
      .gnt_idx (w_idx)
   );
   assign w_any = |w_grant;
   // steer the granted request onto the RAM port, idle port parks at zero
   always_comb begin
      req_ready = w_grant;
      ram_addr  = w_any ? (w_idx[0] ? req_addr[AWIDTH +: AWIDTH] : req_addr[0 +: AWIDTH]) : '0;
      ram_din   = w_any ? (w_idx[0] ? req_wdata[DWIDTH +: DWIDTH] : req_wdata[0 +: DWIDTH]) : '0;
      ram_we    = w_any & req_we[w_idx];
   end
   // remember who was served so the response lands with the RAM read data
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         r_rsp_valid_q <= '0;
         r_rsp_we_q    <= 1'b0;
      end else begin
         r_rsp_valid_q <= w_grant;
         r_rsp_we_q    <= ram_we;
      end
   // response outputs follow the pipeline register; write acks carry no data
   always_comb begin
      rsp_valid = r_rsp_valid_q;
      rsp_we    = r_rsp_we_q;
      rsp_rdata = r_rsp_we_q ? '0 : ram_dout;
   end
endmodule
